// File: rtl/sa_arb_pkg.sv
// ----------------------------------------------------------------------------
// sa_arb_pkg
// Shared types and constants for the two-source packet arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE / LOCK0 / LOCK1)
//   SRC_W       : width of a source id
//   PERF_CNT_W  : width of the optional per-source packet counters
//   lock_of()   : maps a source id to its packet-lock state
// ----------------------------------------------------------------------------
package sa_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam int SRC_W      = 1;
    localparam int PERF_CNT_W = 32;

    function automatic arb_state_e lock_of(input logic src);
        return src ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/sa_rr_pick2.sv
// ----------------------------------------------------------------------------
// sa_rr_pick2
// Combinational two-way round-robin pick.
//   req[1:0] in  : request vector (bit n = source n)
//   ptr      in  : favoured source when both request
//   gnt[1:0] out : one-hot grant, zero when nothing requests
//   gnt_id   out : granted source id; equals ptr when nothing requests
// ----------------------------------------------------------------------------
module sa_rr_pick2
    import sa_arb_pkg::*;
(
    input  logic [1:0]       req,
    input  logic [SRC_W-1:0] ptr,
    output logic [1:0]       gnt,
    output logic [SRC_W-1:0] gnt_id
);

    always_comb begin
        gnt    = 2'b00;
        gnt_id = ptr;
        unique case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ptr;
            default: gnt_id = ptr;
        endcase
        if (req != 2'b00) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/sa_mux2_arb.sv
// ----------------------------------------------------------------------------
// sa_mux2_arb
// Packet-locked round-robin arbiter for a shared 2:1 data mux feeding one
// downstream valid/ready channel, with a single registered output stage.
//
// Parameters
//   DW       payload width per beat
//   RR_INIT  source favoured first after reset (0 or 1)
//
// Ports
//   core_clk, core_rstn          clock, async active-low reset
//   in0_vld/rdy/pd/last          source 0 beat channel
//   in1_vld/rdy/pd/last          source 1 beat channel
//   out_vld/rdy/pd/last/src      registered output beat + source id
//   mux_sel                      current mux select (0 = in0, 1 = in1)
//   perf_cnt0/1                  accepted-packet counts (SA_MUX2_ARB_PERF_EN only)
//
// Build option: define SA_MUX2_ARB_PERF_EN to add the saturating per-source
// packet counters and their ports.
//
// FSM states
//   state | meaning
//   IDLE  | between packets; round-robin pick among valid sources
//   LOCK0 | mid-packet from source 0; only source 0 may transfer
//   LOCK1 | mid-packet from source 1; only source 1 may transfer
// ----------------------------------------------------------------------------
module sa_mux2_arb
    import sa_arb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int RR_INIT = 0
) (
    input  logic          core_clk,
    input  logic          core_rstn,

    input  logic          in0_vld,
    output logic          in0_rdy,
    input  logic [DW-1:0] in0_pd,
    input  logic          in0_last,

    input  logic          in1_vld,
    output logic          in1_rdy,
    input  logic [DW-1:0] in1_pd,
    input  logic          in1_last,

    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_pd,
    output logic          out_last,
    output logic          out_src,

    output logic          mux_sel
`ifdef SA_MUX2_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_cnt0,
    output logic [PERF_CNT_W-1:0] perf_cnt1
`endif
);

    localparam logic RR_INIT_B = (RR_INIT != 0);

    arb_state_e       state_q, state_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [1:0]       pick_gnt;
    logic [SRC_W-1:0] pick_id;
    logic [1:0]       grant;
    logic [SRC_W-1:0] sel;
    logic             ld;
    logic             xfer;
    logic [DW-1:0]    sel_pd;
    logic             sel_last;

    sa_rr_pick2 u_pick (
        .req    ({in1_vld, in0_vld}),
        .ptr    (rr_ptr_q),
        .gnt    (pick_gnt),
        .gnt_id (pick_id)
    );

    // The pipe can take a new beat when empty or when its beat leaves now.
    assign ld = !out_vld || out_rdy;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant    = 2'b00;
        sel      = rr_ptr_q;

        unique case (state_q)
            IDLE: begin
                grant = pick_gnt;
                sel   = pick_id;
            end
            LOCK0: begin
                grant = 2'b01;
                sel   = 1'b0;
            end
            LOCK1: begin
                grant = 2'b10;
                sel   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is forced low in reset so no source sees a phantom accept.
        in0_rdy = ld && grant[0] && core_rstn;
        in1_rdy = ld && grant[1] && core_rstn;

        xfer     = (in0_vld && in0_rdy) || (in1_vld && in1_rdy);
        sel_pd   = sel ? in1_pd   : in0_pd;
        sel_last = sel ? in1_last : in0_last;

        if (xfer) begin
            if (sel_last) begin
                state_d  = IDLE;
                rr_ptr_d = ~sel;
            end else begin
                state_d  = lock_of(sel);
            end
        end
    end

    assign mux_sel = sel;

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state_q  <= IDLE;
            rr_ptr_q <= RR_INIT_B;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Output stage: out_pd/last/src only update on a transfer, so a drain
    // (out_rdy with nothing accepted) clears out_vld but holds the payload.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            out_vld  <= 1'b0;
            out_pd   <= '0;
            out_last <= 1'b0;
            out_src  <= 1'b0;
        end else if (ld) begin
            out_vld <= xfer;
            if (xfer) begin
                out_pd   <= sel_pd;
                out_last <= sel_last;
                out_src  <= sel;
            end
        end
    end

`ifdef SA_MUX2_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] perf_cnt0_q;
    logic [PERF_CNT_W-1:0] perf_cnt1_q;
    logic                  pkt_done0;
    logic                  pkt_done1;

    assign pkt_done0 = in0_vld && in0_rdy && in0_last;
    assign pkt_done1 = in1_vld && in1_rdy && in1_last;

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            perf_cnt0_q <= '0;
            perf_cnt1_q <= '0;
        end else begin
            if (pkt_done0 && (perf_cnt0_q != '1)) begin
                perf_cnt0_q <= perf_cnt0_q + 1'b1;
            end
            if (pkt_done1 && (perf_cnt1_q != '1)) begin
                perf_cnt1_q <= perf_cnt1_q + 1'b1;
            end
        end
    end

    assign perf_cnt0 = perf_cnt0_q;
    assign perf_cnt1 = perf_cnt1_q;
`else
    // Counters and their ports are not built.
`endif

endmodule
